// File: rtl/alu_exec_unit.sv
// Execute-stage ALU for the MIPS datapath.
// Logical, arithmetic and compare ops complete in a single cycle. Shifts run
// on an iterative one-bit-per-cycle shifter, and upstream stalls on in_ready
// while a shift is in progress.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready for a request; in_ready high
// SHIFT | iterative shift in progress, one bit per edge, counter counts down
// DONE  | result registers valid; hold until out_ready
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluOperation,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             invalid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_SLL = 4'd0;
  localparam logic [3:0] OP_SRL = 4'd1;
  localparam logic [3:0] OP_SRA = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_NOR = 4'd8;
  localparam logic [3:0] OP_SLT = 4'd9;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       shift_op;
  logic [WIDTH-1:0] shift_reg;
  logic [4:0]       cnt;

  logic             accept;
  logic             is_shift;
  logic             start_shift;
  logic             last_shift;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_inv;
  logic [WIDTH-1:0] shifted;

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign is_shift    = (aluOperation == OP_SLL) || (aluOperation == OP_SRL) ||
                       (aluOperation == OP_SRA);
  // Zero-length shifts bypass the iterative shifter and finish like any other op.
  assign start_shift = is_shift && (shamt != 5'd0);
  assign last_shift  = (state == SHIFT) && (cnt == 5'd1);
  assign sum         = operandA + operandB;
  assign diff        = operandA - operandB;

  // Single-cycle result, flags and invalid decode from the request inputs.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_inv = 1'b0;
    case (aluOperation)
      OP_SLL, OP_SRL, OP_SRA: alu_res = operandB;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                  (sum[WIDTH-1] != operandA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                  (diff[WIDTH-1] != operandA[WIDTH-1]);
      end
      OP_AND: alu_res = operandA & operandB;
      OP_OR:  alu_res = operandA | operandB;
      OP_XOR: alu_res = operandA ^ operandB;
      OP_NOR: alu_res = ~(operandA | operandB);
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
      default: alu_inv = 1'b1;
    endcase
  end

  // One-bit step of the iterative shifter; shift_op holds the latched op[1:0].
  always_comb begin
    shifted = shift_reg;
    case (shift_op)
      2'd0:    shifted = {shift_reg[WIDTH-2:0], 1'b0};
      2'd1:    shifted = {1'b0, shift_reg[WIDTH-1:1]};
      2'd2:    shifted = {shift_reg[WIDTH-1], shift_reg[WIDTH-1:1]};
      default: shifted = shift_reg;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = start_shift ? SHIFT : DONE;
      SHIFT:   if (cnt == 5'd1) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shifter datapath: load on accept, then step and count down while shifting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_op  <= 2'd0;
      shift_reg <= '0;
      cnt       <= 5'd0;
    end else if (accept) begin
      shift_op  <= aluOperation[1:0];
      shift_reg <= operandB;
      cnt       <= shamt;
    end else if (state == SHIFT) begin
      shift_reg <= shifted;
      cnt       <= cnt - 5'd1;
    end
  end

  // Result registers load only when an operation completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else if (accept && !start_shift) begin
      result   <= alu_res;
      zero     <= (alu_res == '0);
      overflow <= alu_ovf;
      invalid  <= alu_inv;
    end else if (last_shift) begin
      result   <= shifted;
      zero     <= (shifted == '0);
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table plus shift/stall/reset sequences.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  aluOperation;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        invalid;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        inv;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .aluOperation(aluOperation),
    .operandA(operandA),
    .operandB(operandB),
    .shamt(shamt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .zero(zero),
    .overflow(overflow),
    .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int   edges;
    logic ready_seen;
    @(negedge clk);
    chk({name, ":ready_before"}, 32'(in_ready), 32'd1);
    in_valid     = 1'b1;
    aluOperation = v.op;
    operandA     = v.a;
    operandB     = v.b;
    shamt        = v.sh;
    out_ready    = 1'b0;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    edges      = 0;
    ready_seen = 1'b0;
    while (!out_valid && edges < 100) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
    chk({name, ":latency"},  32'(edges), 32'(v.lat));
    chk({name, ":result"},   result, v.res);
    chk({name, ":zero"},     32'(zero), 32'(v.z));
    chk({name, ":overflow"}, 32'(overflow), 32'(v.o));
    chk({name, ":invalid"},  32'(invalid), 32'(v.inv));
    chk({name, ":ready_busy"}, 32'(ready_seen | in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, ":ready_after"}, 32'(in_ready), 32'd1);
    chk({name, ":valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          edges;
    logic        ready_seen;
    logic [31:0] held_res;

    //        op     A             B             sh     result        z     o     inv   lat
    vecs[0]  = '{4'd3, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b1, 1'b0, 0};
    vecs[1]  = '{4'd4, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 0};
    vecs[2]  = '{4'd5, 32'hF0F0F0F0, 32'hFFFF0000, 5'd0,  32'hF0F00000, 1'b0, 1'b0, 1'b0, 0};
    vecs[3]  = '{4'd8, 32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0};
    vecs[4]  = '{4'd0, 32'h0000ABCD, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0, 1'b0, 0};
    vecs[5]  = '{4'd1, 32'h00000000, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0, 1'b0, 31};
    vecs[6]  = '{4'd9, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0, 1'b0, 0};
    vecs[7]  = '{4'd9, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 0};
    vecs[8]  = '{4'hF, 32'h12345678, 32'h9ABCDEF0, 5'd3,  32'h00000000, 1'b1, 1'b0, 1'b1, 0};
    vecs[9]  = '{4'd4, 32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 0};
    vecs[10] = '{4'd6, 32'h12340000, 32'h00005678, 5'd0,  32'h12345678, 1'b0, 1'b0, 1'b0, 0};
    vecs[11] = '{4'd7, 32'hFFFF0000, 32'hFF00FF00, 5'd0,  32'h00FFFF00, 1'b0, 1'b0, 1'b0, 0};
    vecs[12] = '{4'd0, 32'h00000000, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0, 1'b0, 31};
    vecs[13] = '{4'd3, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b0, 0};
    vecs[14] = '{4'hA, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b1, 1'b0, 1'b1, 0};
    vecs[15] = '{4'd1, 32'h00000000, 32'hF0000000, 5'd4,  32'h0F000000, 1'b0, 1'b0, 1'b0, 4};

    reset        = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    aluOperation = 4'd0;
    operandA     = '0;
    operandB     = '0;
    shamt        = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("reset:in_ready",  32'(in_ready), 32'd1);
    chk("reset:out_valid", 32'(out_valid), 32'd0);
    chk("reset:result",    result, 32'd0);
    chk("reset:zero",      32'(zero), 32'd0);
    chk("reset:overflow",  32'(overflow), 32'd0);
    chk("reset:invalid",   32'(invalid), 32'd0);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // SRA by 4 with a stray request mid-shift, then a 3-cycle downstream stall.
    @(negedge clk);
    in_valid     = 1'b1;
    aluOperation = 4'd2;
    operandA     = 32'h0;
    operandB     = 32'h80000000;
    shamt        = 5'd4;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    edges      = 0;
    ready_seen = 1'b0;
    while (!out_valid && edges < 100) begin
      @(negedge clk);
      in_valid = (edges == 1);
      if (edges == 1) begin
        aluOperation = 4'd3;
        operandA     = 32'd1;
        operandB     = 32'd1;
        shamt        = 5'd0;
      end
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      edges++;
    end
    in_valid = 1'b0;
    chk("sra:latency",    32'(edges), 32'd4);
    chk("sra:result",     result, 32'hF8000000);
    chk("sra:zero",       32'(zero), 32'd0);
    chk("sra:ready_busy", 32'(ready_seen), 32'd0);
    held_res = result;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d:out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d:in_ready", k),  32'(in_ready), 32'd0);
      chk($sformatf("stall%0d:result", k),    result, held_res);
      chk($sformatf("stall%0d:flags", k),     {29'd0, zero, overflow, invalid}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("sra:consumed_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("sra:stray_ignored", 32'(out_valid), 32'd0);
    chk("sra:result_kept",   result, 32'hF8000000);

    // Reset in the middle of a 20-bit shift.
    @(negedge clk);
    in_valid     = 1'b1;
    aluOperation = 4'd0;
    operandA     = 32'h0;
    operandB     = 32'h00000001;
    shamt        = 5'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("rst_mid:busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_mid:out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid:result",    result, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid:in_ready",  32'(in_ready), 32'd1);
    chk("rst_mid:idle",      32'(out_valid), 32'd0);
    run_vec(vecs[0], "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
